// File: rtl/attack_sched_pkg.sv
// Shared game definitions: attack FSM states, player indices, damage values.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package attack_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FIRE = 3'd1,
    S_WAIT = 3'd2,
    S_COOL = 3'd3,
    S_OVER = 3'd4
  } state_t;

  localparam logic P_SNOW = 1'b0;
  localparam logic P_FIRE = 1'b1;

  localparam logic [3:0] DMG_BASE = 4'd1;
  localparam logic [3:0] DMG_EVO  = 4'd2;

  // Hit-point subtraction that stops at zero instead of wrapping.
  function automatic logic [3:0] sat_sub(input logic [3:0] a, input logic [3:0] b);
    return (a > b) ? (a - b) : 4'd0;
  endfunction

endpackage

// File: rtl/attack_sched_rr_arb2.sv
// Two-way round-robin arbiter; pointer moves to the loser after every grant.
// Latency: combinational grant, pointer updates on the granting clock edge.
// Backpressure: grants only while i_en is high; no request is stored.
module rr_arb2
  import attack_sched_pkg::*;
(
  input  logic       clk,
  input  logic       clr_n,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_gnt
);

  // Index of the player granted most recently; 1 after reset so player 0 wins a tie.
  logic       r_last;
  logic [1:0] w_gnt;

  // Single requester wins outright; a tie goes to the player not served last.
  always_comb begin
    w_gnt = 2'b00;
    if (i_en) begin
      case (i_req)
        2'b01:   w_gnt = 2'b01;
        2'b10:   w_gnt = 2'b10;
        2'b11:   w_gnt = (r_last == P_FIRE) ? 2'b01 : 2'b10;
        default: w_gnt = 2'b00;
      endcase
    end
  end

  // Remember who was served so the next tie flips.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_last <= P_FIRE;
    end else if (|w_gnt) begin
      r_last <= w_gnt[1];
    end
  end

  assign o_gnt = w_gnt;

endmodule

// File: rtl/attack_sched.sv
// Two-player attack scheduler sharing one projectile engine, with hit points and cooldown.
// Latency: gnt in the request cycle when idle, start one cycle later, COOLDOWN idle cycles after each landing.
// Backpressure: requests are level-sampled only in IDLE; requests in other states are dropped, not queued.
module attack_sched
  import attack_sched_pkg::*;
#(
  parameter int unsigned COOLDOWN = 16,
  parameter int unsigned HP_INIT  = 8
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [1:0] req,
  input  logic [1:0] evolved,
  input  logic       eng_done,
  output logic [1:0] gnt,
  output logic       start,
  output logic       who,
  output logic [3:0] hp0,
  output logic [3:0] hp1,
  output logic       game_over,
  output logic       winner
);

  localparam logic [15:0] CNT_LOAD = 16'(COOLDOWN - 1);
  localparam logic [3:0]  HP_RST   = 4'(HP_INIT);

  state_t      r_state;
  logic        r_start;
  logic        r_who;
  logic        r_str;
  logic [3:0]  r_hp0;
  logic [3:0]  r_hp1;
  logic        r_over;
  logic        r_winner;
  logic [15:0] r_cnt;

  logic        w_arb_en;
  logic [1:0]  w_gnt;
  logic [3:0]  w_dmg;
  logic [3:0]  w_opp_hp;
  logic [3:0]  w_new_hp;

  // Grants are only possible in IDLE; gating with clr_n keeps gnt low the instant reset falls.
  assign w_arb_en = (r_state == S_IDLE) && clr_n;

  rr_arb2 u_arb (
    .clk   (clk),
    .clr_n (clr_n),
    .i_req (req),
    .i_en  (w_arb_en),
    .o_gnt (w_gnt)
  );

  // Damage of the shot in flight, applied to the shooter's opponent.
  assign w_dmg    = r_str ? DMG_EVO : DMG_BASE;
  assign w_opp_hp = (r_who == P_FIRE) ? r_hp0 : r_hp1;
  assign w_new_hp = sat_sub(w_opp_hp, w_dmg);

  // Attack FSM: grant, launch, wait for landing, apply damage, cool down or end the game.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state  <= S_IDLE;
      r_start  <= 1'b0;
      r_who    <= P_SNOW;
      r_str    <= 1'b0;
      r_hp0    <= HP_RST;
      r_hp1    <= HP_RST;
      r_over   <= 1'b0;
      r_winner <= 1'b0;
      r_cnt    <= 16'd0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|w_gnt) begin
            r_who   <= w_gnt[1];
            r_start <= 1'b1;
            r_state <= S_FIRE;
          end
        end
        S_FIRE: begin
          // Strength is frozen here so later evolution does not alter the shot.
          r_str   <= evolved[r_who];
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (eng_done) begin
            if (r_who == P_FIRE) begin
              r_hp0 <= w_new_hp;
            end else begin
              r_hp1 <= w_new_hp;
            end
            if (w_new_hp == 4'd0) begin
              r_over   <= 1'b1;
              r_winner <= r_who;
              r_state  <= S_OVER;
            end else begin
              r_cnt   <= CNT_LOAD;
              r_state <= S_COOL;
            end
          end
        end
        S_COOL: begin
          if (r_cnt == 16'd0) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        S_OVER: begin
          r_state <= S_OVER;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt       = w_gnt;
  assign start     = r_start;
  assign who       = r_who;
  assign hp0       = r_hp0;
  assign hp1       = r_hp1;
  assign game_over = r_over;
  assign winner    = r_winner;

endmodule

// File: tb/tb_attack_sched.sv
// Scoreboard bench for attack_sched: a shot-level game model predicts grant/start events and hit points.
module tb_attack_sched;

  localparam int COOLDOWN = 16;
  localparam int HP_INIT  = 8;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] evolved = 2'b00;
  logic       eng_done = 1'b0;
  logic [1:0] gnt;
  logic       start;
  logic       who;
  logic [3:0] hp0;
  logic [3:0] hp1;
  logic       game_over;
  logic       winner;

  attack_sched #(.COOLDOWN(COOLDOWN), .HP_INIT(HP_INIT)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .req       (req),
    .evolved   (evolved),
    .eng_done  (eng_done),
    .gnt       (gnt),
    .start     (start),
    .who       (who),
    .hp0       (hp0),
    .hp1       (hp1),
    .game_over (game_over),
    .winner    (winner)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       cyc;
    bit       is_start;
    logic [1:0] val;
  } ev_t;

  ev_t q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Game model: hit points, whose shot is in flight, when the engine becomes free again.
  int m_hp[2];
  bit m_over;
  int m_winner;
  bit m_inflight;
  int m_owner;
  int m_start_cyc;
  int m_delay;
  bit m_str;
  int m_idle_from;
  int m_last;
  int m_shots;

  // Expected registered outputs visible during the current cycle.
  int exp_hp0, exp_hp1, exp_who, exp_win;
  bit exp_over;

  // Stimulus knobs.
  int k_req, k_evo, k_delay, k_spur;
  bit k_req_rand, k_evo_rand;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_hp[0] = HP_INIT; m_hp[1] = HP_INIT;
    m_over = 0; m_winner = 0; m_inflight = 0; m_owner = 0;
    m_str = 0; m_last = 1; m_idle_from = 0; m_start_cyc = 0;
    exp_hp0 = HP_INIT; exp_hp1 = HP_INIT; exp_who = 0; exp_win = 0; exp_over = 0;
    q.delete();
  endtask

  task automatic model_step(input logic [1:0] r, input logic [1:0] e, input logic d);
    int dmg, opp, g;
    ev_t ev;
    if (m_over) return;
    if (m_inflight) begin
      if (cyc == m_start_cyc) begin
        m_str = e[m_owner];
      end else if (d) begin
        dmg = m_str ? 2 : 1;
        opp = 1 - m_owner;
        m_hp[opp] = (m_hp[opp] > dmg) ? m_hp[opp] - dmg : 0;
        m_inflight = 0;
        m_shots++;
        if (m_hp[opp] == 0) begin
          m_over = 1;
          m_winner = m_owner;
        end else begin
          m_idle_from = cyc + COOLDOWN + 1;
        end
      end
    end else if (cyc >= m_idle_from && r != 2'b00) begin
      g = (r == 2'b11) ? (1 - m_last) : int'(r[1]);
      m_last = g;
      m_owner = g;
      m_inflight = 1;
      m_start_cyc = cyc + 1;
      m_delay = (k_delay == 0) ? int'($urandom_range(1, 6)) : k_delay;
      ev.cyc = cyc; ev.is_start = 0; ev.val = (g == 1) ? 2'b10 : 2'b01;
      q.push_back(ev);
      ev.cyc = cyc + 1; ev.is_start = 1; ev.val = 2'b00;
      q.push_back(ev);
    end
  endtask

  task automatic snapshot();
    exp_hp0 = m_hp[0]; exp_hp1 = m_hp[1];
    exp_who = m_owner; exp_over = m_over; exp_win = m_winner;
  endtask

  task automatic step_f(input logic [1:0] r, input logic [1:0] e, input logic d);
    @(posedge clk);
    cyc++;
    #1;
    snapshot();
    req = r; evolved = e; eng_done = d;
    model_step(r, e, d);
  endtask

  task automatic step();
    logic [1:0] r, e;
    logic d;
    r = k_req_rand ? 2'($urandom_range(0, 3)) : 2'(k_req);
    e = k_evo_rand ? 2'($urandom_range(0, 3)) : 2'(k_evo);
    d = 1'b0;
    if (m_inflight && (cyc + 1) == m_start_cyc + m_delay) d = 1'b1;
    else if (int'($urandom_range(0, 99)) < k_spur) d = 1'b1;
    step_f(r, e, d);
  endtask

  task automatic do_reset();
    @(posedge clk);
    cyc++;
    #1;
    clr_n = 1'b0; req = 2'b11; eng_done = 1'b0;
    model_reset();
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_start", start, 0);
    chk("rst_who", who, 0);
    chk("rst_hp0", hp0, HP_INIT);
    chk("rst_hp1", hp1, HP_INIT);
    chk("rst_over", game_over, 0);
    chk("rst_winner", winner, 0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      cyc++;
      #1;
      eng_done = 1'b1;
    end
    @(posedge clk);
    cyc++;
    #1;
    clr_n = 1'b1; req = 2'b00; eng_done = 1'b0;
    m_idle_from = cyc;
  endtask

  // Monitor: pops predicted events when the DUT presents gnt/start and tracks registered outputs.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (gnt != 2'b00 && start) chk("gnt_start_overlap", 1, 0);
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        chk(e.is_start ? "missing_start" : "missing_gnt", 0, 1);
      end
      if (gnt != 2'b00) begin
        if (q.size() == 0 || q[0].is_start || q[0].cyc != cyc) begin
          chk("unexpected_gnt", gnt, 0);
        end else begin
          e = q.pop_front();
          chk("gnt", gnt, e.val);
        end
      end
      if (start) begin
        if (q.size() == 0 || !q[0].is_start || q[0].cyc != cyc) begin
          chk("unexpected_start", 1, 0);
        end else begin
          e = q.pop_front();
          chk("start", 1, 1);
        end
      end
      chk("hp0", hp0, exp_hp0);
      chk("hp1", hp1, exp_hp1);
      chk("game_over", game_over, exp_over);
      chk("who", who, exp_who);
      if (exp_over) chk("winner", winner, exp_win);
    end
  end

  initial begin
    int target;
    model_reset();
    m_shots = 0;
    k_req = 0; k_evo = 0; k_delay = 1; k_spur = 0; k_req_rand = 0; k_evo_rand = 0;
    repeat (2) begin @(posedge clk); cyc++; end
    do_reset();

    // Single requester, base strength, landing 5 cycles after start, full cooldown.
    k_req = 1; k_evo = 0; k_delay = 5;
    target = m_shots + 2;
    for (int i = 0; i < 200 && m_shots < target; i++) step();
    chk("bound_single", int'(m_shots >= target), 1);
    k_req = 0;
    repeat (25) step();

    // Both requesting: alternating grants.
    k_req = 3; k_delay = 3;
    target = m_shots + 6;
    for (int i = 0; i < 400 && m_shots < target; i++) step();
    chk("bound_alternate", int'(m_shots >= target), 1);

    // Evolved fireball player wins; no activity afterwards.
    do_reset();
    k_req = 2; k_evo = 2; k_delay = 0;
    for (int i = 0; i < 500 && !m_over; i++) step();
    chk("bound_evolved_win", int'(m_over), 1);
    k_req = 3;
    repeat (30) step();

    // Bring hp0 to 1 with base shots, then an evolved hit must saturate at 0.
    do_reset();
    k_req = 2; k_evo = 0; k_delay = 2;
    for (int i = 0; i < 800 && m_hp[0] > 1; i++) step();
    chk("bound_hp_one", m_hp[0], 1);
    k_evo = 2;
    for (int i = 0; i < 200 && !m_over; i++) step();
    chk("bound_saturate", int'(m_over), 1);
    repeat (5) step();

    // Spurious landings, then reset in WAIT and a stale landing afterwards.
    do_reset();
    k_req = 1; k_evo = 0; k_delay = 6; k_spur = 15;
    repeat (120) step();
    k_spur = 0;
    for (int i = 0; i < 100 && !(m_inflight && cyc >= m_start_cyc + 2); i++) step();
    chk("bound_wait", int'(m_inflight), 1);
    do_reset();
    repeat (3) step_f(2'b00, 2'b00, 1'b1);
    repeat (3) step_f(2'b00, 2'b00, 1'b0);

    // Request raised only during cooldown and dropped before IDLE: no grant.
    k_req = 1; k_delay = 2;
    target = m_shots + 1;
    for (int i = 0; i < 100 && m_shots < target; i++) step();
    chk("bound_cool", int'(m_shots >= target), 1);
    repeat (5) step_f(2'b01, 2'b00, 1'b0);
    repeat (25) step_f(2'b00, 2'b00, 1'b0);

    // Randomized games.
    k_req_rand = 1; k_evo_rand = 1; k_delay = 0; k_spur = 5;
    for (int g = 0; g < 6; g++) begin
      do_reset();
      for (int i = 0; i < 1500 && !m_over; i++) step();
      repeat (10) step();
    end

    step_f(2'b00, 2'b00, 1'b0);
    step_f(2'b00, 2'b00, 1'b0);
    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
